// File: rtl/sp_pkg.sv
// Shared constants for the ADC averaging path: sample width, default window depth, filter states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp_pkg;
  localparam int ADC_W      = 12;
  localparam int LOG2_N_DEF = 3;

  // Filter state encoding kept as plain constants so legacy netlists see a 1-bit flop.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/adc_avg_filter_if.sv
// Bundle between the XADC wrapper / optimizer and the averaging filter.
// Latency: n/a (wires only).
// Backpressure: none; ADC_EOC is a one-cycle strobe the filter always accepts.
interface adc_avg_filter_if;
  logic                       ADC_EOC;
  logic [sp_pkg::ADC_W-1:0]   ADC_DATA;
  logic                       CLR;
  logic [sp_pkg::ADC_W-1:0]   V_OUT;
  logic                       V_VALID;
  logic                       FILLED;
  logic [sp_pkg::ADC_W-1:0]   PEAK_V;

  // Sample source / controller side.
  modport master (
    output ADC_EOC, ADC_DATA, CLR,
    input  V_OUT, V_VALID, FILLED, PEAK_V
  );

  // Filter side.
  modport slave (
    input  ADC_EOC, ADC_DATA, CLR,
    output V_OUT, V_VALID, FILLED, PEAK_V
  );
endinterface

// File: rtl/adc_ring_buf.sv
// Window storage: DEPTH x DATA_W distributed RAM, async read and sync write at the same address.
// Latency: read combinational, write lands on the next CLK edge.
// Backpressure: none; WE is honoured every cycle.
module adc_ring_buf #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the accepted sample over the oldest entry; contents are never reset.
  always_ff @(posedge CLK) begin
    if (WE) mem_q[ADDR] <= DIN;
  end

  assign DOUT = mem_q[ADDR];
endmodule

// File: rtl/adc_avg_filter.sv
// Moving average over the last 2**LOG2_N ADC conversions; optional peak hold under ADC_PEAK_HOLD_EN.
// Latency: ADC_EOC sampled at edge k -> V_VALID/V_OUT after edge k+1 (RUN, or Nth fill sample).
// Backpressure: none; an EOC every cycle is absorbed, CLR wins over a same-cycle EOC.
module adc_avg_filter
  import sp_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  adc_avg_filter_if.slave  bus
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = ADC_W + LOG2_N;

  logic [0:0]        state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
  logic              pend_q, pend_d;
  logic [ADC_W-1:0]  v_out_q, v_out_d;
  logic              v_valid_q, v_valid_d;

  logic              accept;
  logic              last_fill;
  logic [ADC_W-1:0]  ring_dout;
  logic [ADC_W-1:0]  old_smp;

  // In FILL, wr_ptr doubles as the fill count: both start at 0 and advance together.
  assign accept    = bus.ADC_EOC & ~bus.CLR;
  assign last_fill = (state_q == ST_FILL) && (wr_ptr_q == LOG2_N'(N - 1));
  assign old_smp   = (state_q == ST_FILL) ? '0 : ring_dout;

  adc_ring_buf #(
    .DATA_W (ADC_W),
    .ADDR_W (LOG2_N)
  ) u_ring (
    .CLK  (CLK),
    .WE   (accept),
    .ADDR (wr_ptr_q),
    .DIN  (bus.ADC_DATA),
    .DOUT (ring_dout)
  );

  // Stage 1: running sum, write pointer, fill FSM and the stage-2 request.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    pend_d   = 1'b0;
    if (bus.CLR) begin
      state_d  = ST_FILL;
      sum_d    = '0;
      wr_ptr_d = '0;
    end else if (accept) begin
      // Modular add/sub is exact: the true window sum always fits SUM_W.
      sum_d    = sum_q + SUM_W'(bus.ADC_DATA) - SUM_W'(old_smp);
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
      pend_d   = (state_q == ST_RUN) || last_fill;
      if (last_fill) state_d = ST_RUN;
    end
  end

  // Stage 2: publish the average one cycle after the sum settles; CLR cancels a pending strobe.
  always_comb begin
    v_out_d   = v_out_q;
    v_valid_d = 1'b0;
    if (pend_q && !bus.CLR) begin
      v_out_d   = sum_q[SUM_W-1:LOG2_N];
      v_valid_d = 1'b1;
    end
  end

  // State registers for both stages.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_FILL;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      pend_q    <= 1'b0;
      v_out_q   <= '0;
      v_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      pend_q    <= pend_d;
      v_out_q   <= v_out_d;
      v_valid_q <= v_valid_d;
    end
  end

  assign bus.V_OUT   = v_out_q;
  assign bus.V_VALID = v_valid_q;
  assign bus.FILLED  = (state_q == ST_RUN);

`ifdef ADC_PEAK_HOLD_EN
  logic [ADC_W-1:0] peak_q, peak_d;

  // Peak follows each new strobed average; ties keep the held value.
  always_comb begin
    peak_d = peak_q;
    if (bus.CLR) begin
      peak_d = '0;
    end else if (v_valid_d && (v_out_d > peak_q)) begin
      peak_d = v_out_d;
    end
  end

  // Peak register, cleared with the rest of the filter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign bus.PEAK_V = peak_q;
`else
  assign bus.PEAK_V = '0;
`endif
endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter: fill, step response, streaming, CLR, async reset, peak hold.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_avg_filter;
  import sp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef ADC_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  adc_avg_filter_if bus_if ();

  adc_avg_filter #(.LOG2_N(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = d;
      tick();
    end
    bus_if.ADC_EOC = 1'b0;
  endtask

  task automatic test_reset;
    bus_if.ADC_EOC  = 1'b0;
    bus_if.ADC_DATA = '0;
    bus_if.CLR      = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus_if.V_OUT !== 12'h000) begin errors++; $display("FAIL reset_vout got=%h exp=000", bus_if.V_OUT); end
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL reset_vvalid got=%b exp=0", bus_if.V_VALID); end
    checks++; if (bus_if.FILLED !== 1'b0) begin errors++; $display("FAIL reset_filled got=%b exp=0", bus_if.FILLED); end
    checks++; if (bus_if.PEAK_V !== 12'h000) begin errors++; $display("FAIL reset_peak got=%h exp=000", bus_if.PEAK_V); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = 12'h100;
      tick();
      checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL fill_novalid[%0d] got=%b exp=0", i, bus_if.V_VALID); end
      if (i == 6) begin
        checks++; if (bus_if.FILLED !== 1'b0) begin errors++; $display("FAIL fill_filled_early got=%b exp=0", bus_if.FILLED); end
      end
    end
    bus_if.ADC_EOC = 1'b0;
    tick();
    checks++; if (bus_if.V_VALID !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", bus_if.V_VALID); end
    checks++; if (bus_if.V_OUT !== 12'h100) begin errors++; $display("FAIL fill_vout got=%h exp=100", bus_if.V_OUT); end
    checks++; if (bus_if.FILLED !== 1'b1) begin errors++; $display("FAIL fill_filled got=%b exp=1", bus_if.FILLED); end
    tick();
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL fill_strobe_len got=%b exp=0", bus_if.V_VALID); end
  endtask

  task automatic test_step;
    logic [11:0] exp_v;
    int nvld = 0;
    for (int i = 1; i <= 8; i++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = 12'h900;
      tick();
      bus_if.ADC_EOC = 1'b0;
      checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL step_early[%0d] got=%b exp=0", i, bus_if.V_VALID); end
      tick();
      exp_v = 12'(32'h100 * (i + 1));
      if (bus_if.V_VALID === 1'b1) nvld++;
      checks++; if (bus_if.V_OUT !== exp_v) begin errors++; $display("FAIL step_vout[%0d] got=%h exp=%h", i, bus_if.V_OUT, exp_v); end
    end
    checks++; if (nvld !== 8) begin errors++; $display("FAIL step_valid_count got=%0d exp=8", nvld); end
  endtask

  task automatic test_clr;
    bus_if.ADC_EOC  = 1'b1;
    bus_if.ADC_DATA = 12'h900;
    tick();
    bus_if.CLR      = 1'b1;
    bus_if.ADC_DATA = 12'hFFF;
    tick();
    bus_if.CLR     = 1'b0;
    bus_if.ADC_EOC = 1'b0;
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL clr_cancel got=%b exp=0", bus_if.V_VALID); end
    checks++; if (bus_if.FILLED !== 1'b0) begin errors++; $display("FAIL clr_filled got=%b exp=0", bus_if.FILLED); end
    checks++; if (bus_if.V_OUT !== 12'h900) begin errors++; $display("FAIL clr_hold got=%h exp=900", bus_if.V_OUT); end
    for (int i = 0; i < 7; i++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = 12'h040;
      tick();
      checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL clr_refill_novalid[%0d] got=%b exp=0", i, bus_if.V_VALID); end
    end
    bus_if.ADC_EOC = 1'b0;
    tick();
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL clr_refill_7 got=%b exp=0", bus_if.V_VALID); end
    checks++; if (bus_if.FILLED !== 1'b0) begin errors++; $display("FAIL clr_refill_filled7 got=%b exp=0", bus_if.FILLED); end
    checks++; if (bus_if.V_OUT !== 12'h900) begin errors++; $display("FAIL clr_refill_hold got=%h exp=900", bus_if.V_OUT); end
    feed(12'h040, 1);
    checks++; if (bus_if.FILLED !== 1'b1) begin errors++; $display("FAIL clr_refill_filled got=%b exp=1", bus_if.FILLED); end
    tick();
    checks++; if (bus_if.V_VALID !== 1'b1) begin errors++; $display("FAIL clr_refill_valid got=%b exp=1", bus_if.V_VALID); end
    checks++; if (bus_if.V_OUT !== 12'h040) begin errors++; $display("FAIL clr_refill_vout got=%h exp=040", bus_if.V_OUT); end
  endtask

  task automatic test_reset_mid;
    feed(12'h200, 5);
    checks++; if (bus_if.V_VALID !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", bus_if.V_VALID); end
    checks++; if (bus_if.V_OUT !== 12'h120) begin errors++; $display("FAIL rmid_pre_vout got=%h exp=120", bus_if.V_OUT); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.V_OUT !== 12'h000) begin errors++; $display("FAIL rmid_vout got=%h exp=000", bus_if.V_OUT); end
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus_if.V_VALID); end
    checks++; if (bus_if.FILLED !== 1'b0) begin errors++; $display("FAIL rmid_filled got=%b exp=0", bus_if.FILLED); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = 12'h080;
      tick();
      checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL rmid_novalid[%0d] got=%b exp=0", i, bus_if.V_VALID); end
    end
    bus_if.ADC_EOC = 1'b0;
    tick();
    checks++; if (bus_if.V_VALID !== 1'b0) begin errors++; $display("FAIL rmid_7 got=%b exp=0", bus_if.V_VALID); end
    feed(12'h080, 1);
    tick();
    checks++; if (bus_if.V_VALID !== 1'b1) begin errors++; $display("FAIL rmid_valid8 got=%b exp=1", bus_if.V_VALID); end
    checks++; if (bus_if.V_OUT !== 12'h080) begin errors++; $display("FAIL rmid_vout8 got=%h exp=080", bus_if.V_OUT); end
  endtask

  task automatic test_back_to_back;
    int  nvld = 0;
    bit  exp_vld;
    logic [11:0] exp_v;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      bus_if.ADC_EOC  = 1'b1;
      bus_if.ADC_DATA = 12'(j);
      tick();
      // Outputs now reflect sample j-1; window of 8 consecutive indices averages to index-4 (floored).
      exp_vld = (j - 1) >= 7;
      if (bus_if.V_VALID === 1'b1) nvld++;
      checks++; if (bus_if.V_VALID !== exp_vld) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", j, bus_if.V_VALID, exp_vld); end
      if (exp_vld) begin
        exp_v = 12'(j - 5);
        checks++; if (bus_if.V_OUT !== exp_v) begin errors++; $display("FAIL b2b_vout[%0d] got=%h exp=%h", j, bus_if.V_OUT, exp_v); end
      end
    end
    bus_if.ADC_EOC = 1'b0;
    tick();
    if (bus_if.V_VALID === 1'b1) nvld++;
    checks++; if (bus_if.V_OUT !== 12'h00F) begin errors++; $display("FAIL b2b_last_vout got=%h exp=00f", bus_if.V_OUT); end
    checks++; if (nvld !== 13) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=13", nvld); end
  endtask

  task automatic test_peak;
    logic [11:0] exp_p;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    feed(12'h300, 8);
    tick();
    exp_p = PEAK_EN ? 12'h300 : 12'h000;
    checks++; if (bus_if.V_OUT !== 12'h300) begin errors++; $display("FAIL peak_v300 got=%h exp=300", bus_if.V_OUT); end
    checks++; if (bus_if.PEAK_V !== exp_p) begin errors++; $display("FAIL peak_after300 got=%h exp=%h", bus_if.PEAK_V, exp_p); end
    feed(12'h700, 8);
    tick();
    checks++; if (bus_if.V_OUT !== 12'h700) begin errors++; $display("FAIL peak_v700 got=%h exp=700", bus_if.V_OUT); end
    feed(12'h500, 8);
    tick();
    exp_p = PEAK_EN ? 12'h700 : 12'h000;
    checks++; if (bus_if.V_OUT !== 12'h500) begin errors++; $display("FAIL peak_v500 got=%h exp=500", bus_if.V_OUT); end
    checks++; if (bus_if.PEAK_V !== exp_p) begin errors++; $display("FAIL peak_hold got=%h exp=%h", bus_if.PEAK_V, exp_p); end
    bus_if.CLR = 1'b1;
    tick();
    bus_if.CLR = 1'b0;
    checks++; if (bus_if.PEAK_V !== 12'h000) begin errors++; $display("FAIL peak_clr got=%h exp=000", bus_if.PEAK_V); end
    checks++; if (bus_if.V_OUT !== 12'h500) begin errors++; $display("FAIL peak_clr_hold got=%h exp=500", bus_if.V_OUT); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_step();
    test_clr();
    test_reset_mid();
    test_back_to_back();
    test_peak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
